bsg_channel_widen_buffer: RTL

//   Downstream partner of the channel narrowing stage. Collects consecutive

---
 rtl/bsg_channel_widen_buffer_if.sv | 31 +++
 rtl/bsg_channel_widen_buffer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/bsg_channel_widen_buffer_if.sv
// Handshake bundle for the widening buffer: narrow valid/ready input side
// and wide valid/yumi output side.
interface bsg_channel_widen_buffer_if #(
    parameter int width_in_p  = 8,
    parameter int width_out_p = 32
);
    logic                   v_i;
    logic [width_in_p-1:0]  data_i;
    logic                   ready_o;
    logic                   v_o;
    logic [width_out_p-1:0] data_o;
    logic                   yumi_i;

    modport master (
        output v_i,
        output data_i,
        output yumi_i,
        input  ready_o,
        input  v_o,
        input  data_o
    );

    modport slave (
        input  v_i,
        input  data_i,
        input  yumi_i,
        output ready_o,
        output v_o,
        output data_o
    );
endinterface

// File: rtl/bsg_channel_widen_buffer.sv
// Reassembles width_in_p-bit chunks into width_out_p-bit words using an
// assembly register backed by a registered output stage.
module bsg_channel_widen_buffer #(
    parameter int width_in_p   = 8,
    parameter int width_out_p  = 32,
    parameter bit lsb_to_msb_p = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bsg_channel_widen_buffer_if.slave ch
);
    localparam int ratio_lp = width_out_p / width_in_p;
    localparam int cnt_w_lp = $clog2(ratio_lp + 1);
    localparam logic [cnt_w_lp-1:0] cnt_zero_lp = {cnt_w_lp{1'b0}};
    localparam logic [cnt_w_lp-1:0] cnt_one_lp  = cnt_w_lp'(1);
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(ratio_lp - 1);
    localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(ratio_lp);

    if (((width_out_p % width_in_p) != 0) || (width_out_p < width_in_p)) begin : g_bad_widths
        $fatal(1, "width_out_p must be a positive multiple of width_in_p");
    end

    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
    logic [width_out_p-1:0] asm_q, asm_d;
    logic [width_out_p-1:0] data_q, data_d;
    logic                   v_q, v_d;

    logic                   accept_s;
    logic                   out_free_s;
    logic                   last_s;
    logic                   full_s;
    logic                   yumi_s;
    logic [cnt_w_lp-1:0]    slot_s;
    logic [width_out_p-1:0] merged_s;

    assign full_s     = (cnt_q == cnt_full_lp);
    assign last_s     = (cnt_q == cnt_last_lp);
    assign accept_s   = ch.v_i & ~full_s;
    // A yumi without a valid word is ignored rather than trusted.
    assign yumi_s     = ch.yumi_i & v_q;
    assign out_free_s = ~v_q | yumi_s;
    assign slot_s     = lsb_to_msb_p ? cnt_q : (cnt_last_lp - cnt_q);

    // Assembly register with the incoming chunk dropped into its slot.
    always_comb begin
        merged_s = asm_q;
        for (int k = 0; k < ratio_lp; k++) begin
            merged_s[k*width_in_p +: width_in_p] = (slot_s == cnt_w_lp'(k)) ?
                ch.data_i : asm_q[k*width_in_p +: width_in_p];
        end
    end

    // Next-state: chunk counting, word hand-off to the output stage, dequeue.
    always_comb begin
        cnt_d  = cnt_q;
        v_d    = v_q;
        data_d = data_q;
        asm_d  = asm_q;

        if (accept_s) begin
            asm_d = merged_s;
        end else begin
            asm_d = asm_q;
        end

        if (accept_s && last_s && out_free_s) begin
            data_d = merged_s;
            v_d    = 1'b1;
            cnt_d  = cnt_zero_lp;
        end else if (accept_s && last_s) begin
            // Output still occupied: park the finished word in the assembly register.
            cnt_d  = cnt_full_lp;
            v_d    = v_q;
        end else if (full_s && out_free_s) begin
            data_d = asm_q;
            v_d    = 1'b1;
            cnt_d  = cnt_zero_lp;
        end else if (accept_s) begin
            cnt_d  = cnt_q + cnt_one_lp;
            v_d    = v_q & ~yumi_s;
        end else begin
            cnt_d  = cnt_q;
            v_d    = v_q & ~yumi_s;
        end
    end

    // State registers; reset discards any partially assembled word.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q  <= cnt_zero_lp;
            asm_q  <= {width_out_p{1'b0}};
            data_q <= {width_out_p{1'b0}};
            v_q    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            asm_q  <= asm_d;
            data_q <= data_d;
            v_q    <= v_d;
        end
    end

    assign ch.ready_o = ~full_s;
    assign ch.v_o     = v_q;
    assign ch.data_o  = data_q;

    bsg_channel_widen_buffer_chk u_chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_o       (v_q),
        .yumi_i    (ch.yumi_i)
    );
endmodule

// Protocol checks on the output handshake.
module bsg_channel_widen_buffer_chk (
    input logic clk_i,
    input logic reset_n_i,
    input logic v_o,
    input logic yumi_i
);
    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    ) else $error("yumi_i asserted while v_o is low");
endmodule
